// File: rtl/elastic_port_pipe.sv
// elastic_port_pipe: DEPTH-stage valid/ready register pipeline with a wrapping output-transfer counter
module elastic_port_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_count
);
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("elastic_port_pipe: DEPTH must be in 1..8");
    end
    logic             v [DEPTH];
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH:0]   rdy;
    // Ready ripples back combinationally so a full pipe can shift and accept in one cycle
    always_comb begin
        rdy[DEPTH] = out_ready;
        for (int s = DEPTH - 1; s >= 0; s--) rdy[s] = !v[s] || rdy[s+1];
    end
    genvar i;
    for (i = 0; i < DEPTH; i++) begin : g_stage
        logic             pv;
        logic [WIDTH-1:0] pd;
        if (i == 0) begin : g_head
            assign pv = in_valid;
            assign pd = in_data;
        end else begin : g_body
            assign pv = v[i-1];
            assign pd = d[i-1];
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                v[i] <= 1'b0;
                d[i] <= '0;
            end else if (rdy[i]) begin
                v[i] <= pv;
                if (pv) d[i] <= pd;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) xfer_count <= '0;
        else if (out_valid && out_ready) xfer_count <= xfer_count + CNT_W'(1);
    end
    assign in_ready  = rdy[0];
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
endmodule

// File: tb/tb_elastic_port_pipe.sv
// tb_elastic_port_pipe: three pipe configurations (D2/C16, D1/C2, D8/C16) on shared stimulus, queue scoreboards per DUT
module tb_elastic_port_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]        ov, ir;
    logic [2:0][31:0]  od;
    logic [2:0][15:0]  cn;
    int total = 0;
    int bad = 0;
    int pend [3];
    always #5 clk = ~clk;
    function automatic int dep(input int k);
        return (k == 0) ? 2 : (k == 1) ? 1 : 8;
    endfunction
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
    endtask
    genvar k;
    for (k = 0; k < 3; k++) begin : g_dut
        localparam int DEP = (k == 0) ? 2 : (k == 1) ? 1 : 8;
        localparam int CW  = (k == 1) ? 2 : 16;
        logic [CW-1:0]  cnt;
        logic [31:0]    q [$];
        int             cm = 0;
        logic           hold = 1'b0;
        logic [31:0]    held = '0;
        elastic_port_pipe #(.WIDTH(32), .DEPTH(DEP), .CNT_W(CW)) u_dut (
            .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(ir[k]),
            .out_data(od[k]), .out_valid(ov[k]), .out_ready(out_ready), .xfer_count(cnt)
        );
        assign cn[k] = 16'(cnt);
        // Model state is updated with the handshakes that the next posedge will perform
        always @(negedge clk) begin
            if (reset) begin
                q.delete();
                cm = 0;
                hold = 1'b0;
            end else begin
                check($sformatf("count%0d", k), cnt, cm % (1 << CW));
                check($sformatf("in_ready%0d", k), ir[k], (q.size() < DEP) || out_ready);
                if (q.size() == 0) check($sformatf("empty_valid%0d", k), ov[k], 1'b0);
                if (q.size() == DEP) check($sformatf("full_valid%0d", k), ov[k], 1'b1);
                if (hold) check($sformatf("stall_hold%0d", k), {ov[k], od[k]}, {1'b1, held});
                if (ov[k] && out_ready) begin
                    check($sformatf("sb_nonempty%0d", k), q.size() != 0, 1'b1);
                    if (q.size() != 0) check($sformatf("data%0d", k), od[k], q.pop_front());
                    cm++;
                end
                if (in_valid && ir[k]) q.push_back(in_data);
                hold = ov[k] && !out_ready;
                held = od[k];
            end
            pend[k] = q.size();
        end
    end
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int lat [3];
        logic [31:0] w [3];
        logic [1:0] last;
        int n;
        repeat (2) step();
        reset = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 3; j++) check($sformatf("rst_state%0d", j), {ov[j], od[j], cn[j], ir[j]}, {1'b1, 32'h0, 16'h0, 1'b1} ^ {1'b1, 49'h0});
        step();
        // Latency: one word into empty pipes with out_ready held high
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 32'h11223344;
        step();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) lat[j] = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int j = 0; j < 3; j++) begin
                if (lat[j] < 0 && ov[j]) begin
                    lat[j] = c;
                    check($sformatf("lat_data%0d", j), od[j], 32'h11223344);
                end
            end
            if (c == 1) check("cnt_before_consume", cn[0], 16'd0);
            if (c == 2) check("cnt_after_consume", cn[0], 16'd1);
            step();
        end
        for (int j = 0; j < 3; j++) check($sformatf("latency%0d", j), 64'(lat[j]), 64'(dep(j) - 1));
        // Back-to-back stream, no bubbles
        do_reset();
        w[0] = 32'h44332211;
        w[1] = 32'hDEADBEEF;
        w[2] = 32'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 3);
            in_data = (i < 3) ? w[i] : 32'h5555_5555;
            @(negedge clk);
            if (i >= 1) check($sformatf("stream_valid%0d", i), ov[0], (i >= 2 && i <= 4));
            if (i >= 2 && i <= 4) check($sformatf("stream_data%0d", i), od[0], w[i-2]);
            if (i == 5) check("stream_count", cn[0], 16'd3);
            step();
        end
        in_valid = 1'b0;
        // Fill and stall, then release
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA0;
        step();
        in_data = 32'hA1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d", i), {ir[0], ov[0], od[0]}, {1'b0, 1'b1, 32'hA0});
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("release_valid%0d", i), ov[0], i < 2);
            if (i < 2) check($sformatf("release_data%0d", i), od[0], (i == 0) ? 32'hA0 : 32'hA1);
            step();
        end
        // Full pipe: leave, shift and enter in one cycle
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hA0;
        step();
        in_data = 32'hA1;
        step();
        out_ready = 1'b1;
        in_data = 32'hB0;
        @(negedge clk);
        check("full_pass_ready", ir[0], 1'b1);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("full_pass_state", {ir[0], ov[0], od[0]}, {1'b0, 1'b1, 32'hA1});
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("pass_drain_valid%0d", i), ov[0], i < 2);
            if (i < 2) check($sformatf("pass_drain_data%0d", i), od[0], (i == 0) ? 32'hA1 : 32'hB0);
            step();
        end
        // Reset with words in flight
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hC0;
        step();
        in_data = 32'hC1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("midrst_out%0d", j), {ov[j], od[j]}, 33'h0);
            check($sformatf("midrst_cnt%0d", j), cn[j], 16'h0);
            check($sformatf("midrst_rdy%0d", j), ir[j], 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            check($sformatf("midrst_quiet%0d", i), ov[0] | ov[1] | ov[2], 1'b0);
        end
        step();
        // Counter wrap on the 2-bit instance
        do_reset();
        out_ready = 1'b1;
        last = 2'd0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 5);
            in_data = $urandom;
            @(negedge clk);
            if (cn[1][1:0] != last) begin
                check($sformatf("wrap_seq%0d", n), cn[1], 16'((n + 1) % 4));
                n++;
                last = cn[1][1:0];
            end
            step();
        end
        check("wrap_steps", 64'(n), 64'd5);
        // Random traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            if (c == 700) reset = 1'b1;
            step();
            reset = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        @(negedge clk);
        for (int j = 0; j < 3; j++) check($sformatf("drained%0d", j), 64'(pend[j]), 64'd0);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
